// File: rtl/tx_pull_unit.sv
// TX FIFO feeding the output shift register: buffers system words and resolves
// PULL / OUT / autopull requests into same-cycle OSR load and shift controls.
module tx_pull_unit #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              pull_req,
    input  logic              pull_block,
    input  logic [DATA_W-1:0] x_data,
    input  logic              out_req,
    input  logic [5:0]        out_count,
    input  logic              autopull_en,
    input  logic [5:0]        pull_thresh,
    output logic              pull_done,
    output logic              out_done,
    output logic              stall,
    output logic              osr_load,
    output logic [DATA_W-1:0] osr_data,
    output logic              osr_shift_en,
    output logic [5:0]        osr_shift_count,
    output logic [5:0]        osr_count,
    output logic [LW-1:0]     fifo_level,
    output logic              tx_empty,
    output logic              tx_full
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [5:0]        osr_count_q, osr_count_d;

    logic       push, pop;
    logic [6:0] thresh, nbits, osr_sum;
    logic       refill_due;

    assign tx_empty   = (level_q == '0);
    assign tx_full    = (level_q == LW'(DEPTH));
    assign wr_ready   = !tx_full;
    assign fifo_level = level_q;
    assign osr_count  = osr_count_q;
    assign push       = wr_valid && wr_ready;

    // Zero encodings of 32 are widened to 7 bits so 32 is representable in compares and sums.
    assign thresh     = (pull_thresh == 6'd0) ? 7'd32 : {1'b0, pull_thresh};
    assign nbits      = (out_count == 6'd0) ? 7'd32 : {1'b0, out_count};
    assign osr_sum    = {1'b0, osr_count_q} + nbits;
    assign refill_due = autopull_en && ({1'b0, osr_count_q} >= thresh);

    always_comb begin
        pull_done       = 1'b0;
        out_done        = 1'b0;
        stall           = 1'b0;
        osr_load        = 1'b0;
        osr_data        = '0;
        osr_shift_en    = 1'b0;
        osr_shift_count = 6'd0;
        pop             = 1'b0;
        osr_count_d     = osr_count_q;

        if (pull_req) begin
            if (autopull_en && !refill_due) begin
                pull_done = 1'b1;
            end else if (!tx_empty) begin
                osr_load    = 1'b1;
                osr_data    = mem_q[rd_ptr_q];
                pop         = 1'b1;
                osr_count_d = 6'd0;
                pull_done   = 1'b1;
            end else if (pull_block) begin
                stall = 1'b1;
            end else begin
                osr_load    = 1'b1;
                osr_data    = x_data;
                osr_count_d = 6'd0;
                pull_done   = 1'b1;
            end
        end else if (out_req) begin
            // A due refill takes the cycle; the OUT is replayed once the OSR is fresh.
            if (refill_due) begin
                stall = 1'b1;
                if (!tx_empty) begin
                    osr_load    = 1'b1;
                    osr_data    = mem_q[rd_ptr_q];
                    pop         = 1'b1;
                    osr_count_d = 6'd0;
                end
            end else begin
                osr_shift_en    = 1'b1;
                osr_shift_count = nbits[5:0];
                osr_count_d     = (osr_sum > 7'd32) ? 6'd32 : osr_sum[5:0];
                out_done        = 1'b1;
            end
        end else if (refill_due && !tx_empty) begin
            osr_load    = 1'b1;
            osr_data    = mem_q[rd_ptr_q];
            pop         = 1'b1;
            osr_count_d = 6'd0;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            osr_count_q <= 6'd32;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            osr_count_q <= osr_count_d;
        end
    end

endmodule

// File: tb/tb_tx_pull_unit.sv
// Scoreboard bench for tx_pull_unit: a queue-based reference model predicts every
// cycle's outputs, and an independent monitor compares them against the DUT.
module tb_tx_pull_unit;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic              pull_req = 1'b0;
    logic              pull_block = 1'b0;
    logic [DATA_W-1:0] x_data = '0;
    logic              out_req = 1'b0;
    logic [5:0]        out_count = '0;
    logic              autopull_en = 1'b0;
    logic [5:0]        pull_thresh = '0;
    logic              pull_done, out_done, stall, osr_load, osr_shift_en;
    logic [DATA_W-1:0] osr_data;
    logic [5:0]        osr_shift_count, osr_count;
    logic [LW-1:0]     fifo_level;
    logic              tx_empty, tx_full;

    tx_pull_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .pull_req(pull_req), .pull_block(pull_block), .x_data(x_data),
        .out_req(out_req), .out_count(out_count),
        .autopull_en(autopull_en), .pull_thresh(pull_thresh),
        .pull_done(pull_done), .out_done(out_done), .stall(stall),
        .osr_load(osr_load), .osr_data(osr_data),
        .osr_shift_en(osr_shift_en), .osr_shift_count(osr_shift_count),
        .osr_count(osr_count), .fifo_level(fifo_level),
        .tx_empty(tx_empty), .tx_full(tx_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_ready, pull_done, out_done, stall, osr_load, osr_shift_en;
        logic        tx_empty, tx_full;
        logic [31:0] osr_data;
        int          shift_count, osr_count, level;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fifo_m[$];
    int          oc_m = 32;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic exp_t idle_view();
        exp_t e;
        e = '{default: 0};
        e.wr_ready  = (fifo_m.size() < DEPTH);
        e.level     = fifo_m.size();
        e.tx_empty  = (fifo_m.size() == 0);
        e.tx_full   = (fifo_m.size() == DEPTH);
        e.osr_count = oc_m;
        return e;
    endfunction

    // Predict this cycle from the current inputs, queue it, advance the model, wait one cycle.
    task automatic cycle();
        exp_t e;
        int   t, n, noc;
        bit   pop, push, due;
        e   = idle_view();
        t   = (pull_thresh == 0) ? 32 : int'(pull_thresh);
        n   = (out_count == 0) ? 32 : int'(out_count);
        due = autopull_en && (oc_m >= t);
        noc = oc_m;
        pop = 0;
        if (pull_req) begin
            if (autopull_en && oc_m < t) e.pull_done = 1;
            else if (fifo_m.size() > 0) begin
                e.osr_load = 1; e.osr_data = fifo_m[0]; pop = 1; noc = 0; e.pull_done = 1;
            end else if (pull_block) e.stall = 1;
            else begin
                e.osr_load = 1; e.osr_data = x_data; noc = 0; e.pull_done = 1;
            end
        end else if (out_req) begin
            if (due) begin
                e.stall = 1;
                if (fifo_m.size() > 0) begin
                    e.osr_load = 1; e.osr_data = fifo_m[0]; pop = 1; noc = 0;
                end
            end else begin
                e.osr_shift_en = 1; e.shift_count = n; e.out_done = 1;
                noc = (oc_m + n > 32) ? 32 : oc_m + n;
            end
        end else if (due && fifo_m.size() > 0) begin
            e.osr_load = 1; e.osr_data = fifo_m[0]; pop = 1; noc = 0;
        end
        push = wr_valid && (fifo_m.size() < DEPTH);
        exp_q.push_back(e);
        if (pop) void'(fifo_m.pop_front());
        if (push) fifo_m.push_back(wr_data);
        oc_m = noc;
        @(negedge clk);
    endtask

    task automatic set_idle();
        wr_valid = 0; pull_req = 0; pull_block = 0; out_req = 0;
        autopull_en = 0; pull_thresh = 0; out_count = 0; x_data = 0; wr_data = 0;
    endtask

    // Monitor: compares whatever the model predicted for the cycle just driven.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_ready", 32'(wr_ready), 32'(e.wr_ready));
                chk("pull_done", 32'(pull_done), 32'(e.pull_done));
                chk("out_done", 32'(out_done), 32'(e.out_done));
                chk("stall", 32'(stall), 32'(e.stall));
                chk("osr_load", 32'(osr_load), 32'(e.osr_load));
                chk("osr_data", osr_data, e.osr_data);
                chk("osr_shift_en", 32'(osr_shift_en), 32'(e.osr_shift_en));
                chk("osr_shift_count", 32'(osr_shift_count), 32'(e.shift_count));
                chk("osr_count", 32'(osr_count), 32'(e.osr_count));
                chk("fifo_level", 32'(fifo_level), 32'(e.level));
                chk("tx_empty", 32'(tx_empty), 32'(e.tx_empty));
                chk("tx_full", 32'(tx_full), 32'(e.tx_full));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1;
        set_idle();
        cycle();                                  // reset state

        // Push A, B, C then a plain PULL of the head
        wr_valid = 1;
        wr_data = 32'hA; cycle();
        wr_data = 32'hB; cycle();
        wr_data = 32'hC; cycle();
        wr_valid = 0; pull_req = 1; cycle();
        pull_req = 0; cycle();
        pull_req = 1; cycle(); cycle();           // drain B, C

        // Blocking PULL on empty, word arrives on the third stalled cycle
        pull_block = 1; cycle(); cycle();
        wr_valid = 1; wr_data = 32'h55; cycle();
        wr_valid = 0; cycle();
        set_idle(); cycle();

        // Non-blocking PULL on empty loads scratch X
        pull_req = 1; x_data = 32'hDEAD; cycle();
        set_idle(); cycle();

        // Autopull threshold 8 with two buffered words, OUT 8 back to back
        wr_valid = 1; wr_data = 32'h1111; cycle();
        wr_data = 32'h2222; cycle();
        wr_valid = 0; autopull_en = 1; pull_thresh = 8; out_req = 1; out_count = 8;
        cycle(); cycle(); cycle();
        set_idle(); pull_req = 1; cycle();        // drain remaining word

        // Fill to full, rejected push during pop, then pointer wrap
        set_idle(); wr_valid = 1;
        for (int i = 0; i < 4; i++) begin wr_data = 32'h100 + i; cycle(); end
        wr_data = 32'h999; pull_req = 1; cycle();
        for (int i = 0; i < 10; i++) begin wr_data = $urandom; cycle(); end

        // OUT of 32 and saturation
        set_idle(); out_req = 1; out_count = 0; cycle(); cycle();

        // Drain, stall on blocking PULL, then async reset mid-stall
        set_idle(); pull_req = 1;
        for (int i = 0; i < 3; i++) cycle();
        pull_block = 1; cycle();
        set_idle();
        #1 rst_n = 0;
        fifo_m.delete(); oc_m = 32;
        exp_q.push_back(idle_view());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wr_valid    = ($urandom % 2) == 0;
            wr_data     = $urandom;
            pull_req    = ($urandom % 4) == 0;
            pull_block  = ($urandom % 2) == 0;
            x_data      = $urandom;
            out_req     = ($urandom % 3) == 0;
            out_count   = 6'($urandom_range(0, 32));
            autopull_en = ($urandom % 4) != 0;
            pull_thresh = 6'($urandom_range(0, 32));
            cycle();
        end
        set_idle();
        @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_pull_unit.md
Name: tx_pull_unit

Overview:
- TX FIFO and pull/autopull controller that sits directly upstream of the output shift register (OSR).
- Buffers system-side 32-bit words in a DEPTH-entry FIFO.
- Services PULL and OUT requests from the state-machine FSM.
- Tracks the OSR shift count and drives the OSR's load, data_in, shift_en and shift_count controls.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
DATA_W, 32, word width; fixed by the OSR.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset, asynchronous, active-low
wr_data  in  DATA_W  system push data
wr_valid  in  1  system push request
wr_ready  out  1  FIFO can accept a word (= !tx_full)
pull_req  in  1  FSM executing PULL
pull_block  in  1  PULL block bit
x_data  in  DATA_W  scratch X value, loaded on non-blocking PULL when FIFO empty
out_req  in  1  FSM executing OUT
out_count  in  6  OUT bit count; 0 encodes 32
autopull_en  in  1  autopull enable (control register)
pull_thresh  in  6  autopull threshold; 0 encodes 32
pull_done  out  1  PULL may retire this cycle
out_done  out  1  OUT may retire this cycle
stall  out  1  FSM must hold the current instruction
osr_load  out  1  to OSR load
osr_data  out  DATA_W  to OSR data_in
osr_shift_en  out  1  to OSR shift_en
osr_shift_count  out  6  to OSR shift_count, range 1..32
osr_count  out  6  bits shifted out since last load, range 0..32
fifo_level  out  $clog2(DEPTH)+1  occupancy
tx_empty  out  1  fifo_level == 0
tx_full  out  1  fifo_level == DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers = 0, fifo_level = 0, osr_count = 32 (OSR empty).
  - All combinational outputs then follow from that state: wr_ready = 1, tx_empty = 1, tx_full = 0.
  - pull_done, out_done, stall, osr_load and osr_shift_en are 0 when no request is active.
  - osr_data = 0 and osr_shift_count = 0 when not loading or shifting.
  - A reset mid-stall discards the pending request; FIFO contents are lost.
- Registered state: FIFO array, read/write pointers (wrap modulo DEPTH), fifo_level, osr_count. All handshake and OSR-control outputs are combinational from state and inputs, so there is zero-cycle latency from request to OSR control.
- Push:
  - Occurs when wr_valid && wr_ready.
  - wr_ready = !tx_full, even if a pop happens in the same cycle.
  - No bypass: a word pushed into an empty FIFO is poppable the next cycle.
- Pop: a simultaneous push and pop leaves fifo_level unchanged.
- Request priority: pull_req > out_req > idle autopull. If both requests are asserted, out_req is ignored and out_done = 0.
- PULL:
  - If autopull_en && osr_count < T (T = pull_thresh, where 0 means 32): no-op, pull_done = 1.
  - Else if FIFO non-empty: osr_load = 1, osr_data = head, pop, osr_count <= 0, pull_done = 1.
  - Else if pull_block: stall = 1, pull_done = 0, no state change.
  - Else: osr_load = 1, osr_data = x_data, osr_count <= 0, pull_done = 1.
- OUT, with N = out_count (0 means 32):
  - If autopull_en && osr_count >= T:
    - FIFO non-empty: osr_load = 1 with head, pop, osr_count <= 0, stall = 1, out_done = 0. The OUT retires on a later cycle.
    - FIFO empty: stall = 1, no state change.
  - Else: osr_shift_en = 1, osr_shift_count = N, osr_count <= min(osr_count + N, 32), out_done = 1.
- Idle autopull: with no request, if autopull_en && osr_count >= T && FIFO non-empty, perform a load and pop, and osr_count <= 0.
- osr_count saturates at 32 and never wraps.
- Width rule: internal sums are 7 bits wide before saturation.

Test Plan:
- Reset, then push 0xA, 0xB, 0xC -> fifo_level = 3. Non-autopull PULL -> same-cycle osr_load = 1, osr_data = 0xA, pull_done = 1; next cycle fifo_level = 2, osr_count = 0.
- Blocking PULL on empty FIFO -> stall = 1 with no load for 3 cycles. Push 0x55 at cycle 3 -> cycle 4 osr_load with 0x55, pull_done = 1, tx_empty = 1 after.
- Non-blocking PULL on empty FIFO with x_data = 0xDEAD -> osr_load = 1, osr_data = 0xDEAD, pull_done = 1, fifo_level unchanged.
- autopull_en = 1, pull_thresh = 8, FIFO holds 2 words, back-to-back OUT 8 each cycle from osr_count = 0:
  - cycle 1: out_done, osr_count = 8.
  - cycle 2: stall with load, osr_count = 0.
  - cycle 3: out_done.
- Push 4 words -> tx_full = 1, wr_ready = 0. A 5th push while popping the same cycle is not accepted; fifo_level = 3 after. Pointer wrap: push/pop 10 more words -> data order preserved.
- out_count = 0 -> osr_shift_count = 32, osr_count saturates at 32. Assert rst_n low mid-stall -> all outputs at reset values immediately, osr_count = 32.
